piso_serializer: RTL and testbench

- Parallel-in, serial-out shift register with a valid/ready load handshake. It is the transmit-side counterpart of the 4-bit serial-in, parallel-out register.
- Accepts a WIDTH-bit word and drives it out one bit per clock on `sout`, with a frame-valid and last-bit marker.
- Supports gapless back-to-back words.
- Sits between a parallel data source and a serial link, or a SIPO receiver in loopback.

---
 rtl/piso_serializer.sv | 84 ++++++++
 tb/tb_piso_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Emits one bit per clock with frame-valid and last-bit markers; supports gapless back-to-back words.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             last_c;
  logic             accept_c;
  logic             out_bit_c;

  assign last_c    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign din_ready = (state == IDLE) || last_c;
  assign accept_c  = din_valid && din_ready;
  assign out_bit_c = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  // State, shift register and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: an accept always reloads, even on the last-bit cycle, so frames abut
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    if (accept_c) begin
      state_nx = SHIFT;
      shreg_nx = din;
      cnt_nx   = '0;
    end else begin
      case (state)
        SHIFT: begin
          if (last_c) begin
            state_nx = IDLE;
            shreg_nx = '0;
            cnt_nx   = '0;
          end else begin
            shreg_nx = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
            cnt_nx   = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state; sout is forced low outside a frame
  assign sout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign sout_last  = last_c;
  assign sout       = sout_valid & out_bit_c;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first 4-bit instance with SIPO loopback, and MSB-first 8-bit instance.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] din4;
  logic       din_valid4;
  logic       din_ready4, sout4, sout_valid4, sout_last4, busy4;
  logic [7:0] din8;
  logic       din_valid8;
  logic       din_ready8, sout8, sout_valid8, sout_last8, busy8;
  logic [3:0] sipo_q;

  int tests;
  int fails;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din_valid4), .din_ready(din_ready4),
    .sout(sout4), .sout_valid(sout_valid4), .sout_last(sout_last4), .busy(busy4)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .din_valid(din_valid8), .din_ready(din_ready8),
    .sout(sout8), .sout_valid(sout_valid8), .sout_last(sout_last8), .busy(busy8)
  );

  // 4-bit SIPO receiver: first-received bit ends at q[0]
  always_ff @(posedge clk) begin
    if (!rst_n) sipo_q <= '0;
    else if (sout_valid4) sipo_q <= {sout4, sipo_q[3:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din4 = 4'h0; din_valid4 = 1'b0;
    din8 = 8'h00; din_valid8 = 1'b0;
    step(); step();
    tests++;
    if ({sout4, sout_valid4, sout_last4, busy4, din_ready4} !== 5'b00001) begin
      fails++;
      $display("FAIL reset4: got {sout,valid,last,busy,ready}=%b want 00001",
               {sout4, sout_valid4, sout_last4, busy4, din_ready4});
    end
    tests++;
    if ({sout8, sout_valid8, sout_last8, busy8, din_ready8} !== 5'b00001) begin
      fails++;
      $display("FAIL reset8: got {sout,valid,last,busy,ready}=%b want 00001",
               {sout8, sout_valid8, sout_last8, busy8, din_ready8});
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (din_ready4 !== 1'b1 || sout_valid4 !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got ready=%b valid=%b want ready=1 valid=0", din_ready4, sout_valid4);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    din4 = 4'b1011; din_valid4 = 1'b1;
    step();
    din_valid4 = 1'b0;
    din4 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({sout4, sout_valid4, sout_last4, din_ready4, busy4} !==
          {exp_bits[i], 1'b1, (i == 3), (i == 3), 1'b1}) begin
        fails++;
        $display("FAIL single cycle %0d: got {sout,valid,last,ready,busy}=%b want %b", i + 1,
                 {sout4, sout_valid4, sout_last4, din_ready4, busy4},
                 {exp_bits[i], 1'b1, (i == 3), (i == 3), 1'b1});
      end
      step();
    end
    tests++;
    if ({sout4, sout_valid4, sout_last4, busy4, din_ready4} !== 5'b00001) begin
      fails++;
      $display("FAIL single idle: got {sout,valid,last,busy,ready}=%b want 00001",
               {sout4, sout_valid4, sout_last4, busy4, din_ready4});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    exp_bits = 8'b0101_1010; // bit i = i-th transmitted bit: A lsb-first then 5 lsb-first
    din4 = 4'hA; din_valid4 = 1'b1;
    step();
    din4 = 4'h5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) din_valid4 = 1'b0;
      tests++;
      if ({sout4, sout_valid4, sout_last4} !== {exp_bits[i], 1'b1, (i == 3 || i == 7)}) begin
        fails++;
        $display("FAIL b2b bit %0d: got {sout,valid,last}=%b want %b", i,
                 {sout4, sout_valid4, sout_last4}, {exp_bits[i], 1'b1, (i == 3 || i == 7)});
      end
      step();
    end
    tests++;
    if ({sout4, sout_valid4} !== 2'b00) begin
      fails++;
      $display("FAIL b2b idle: got {sout,valid}=%b want 00", {sout4, sout_valid4});
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp_bits;
    exp_bits = 8'b1111_0011; // 3 lsb-first then F
    din4 = 4'h3; din_valid4 = 1'b1;
    step();
    din4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) din_valid4 = 1'b0;
      tests++;
      if ({sout4, sout_valid4, din_ready4} !== {exp_bits[i], 1'b1, (i == 3 || i == 7)}) begin
        fails++;
        $display("FAIL busy_ignore bit %0d: got {sout,valid,ready}=%b want %b", i,
                 {sout4, sout_valid4, din_ready4}, {exp_bits[i], 1'b1, (i == 3 || i == 7)});
      end
      step();
    end
    tests++;
    if (sout_valid4 !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore idle: got valid=%b want 0", sout_valid4);
    end
  endtask

  task automatic test_loopback();
    din4 = 4'b0110; din_valid4 = 1'b1;
    step();
    din_valid4 = 1'b0;
    step(); step(); step();
    tests++;
    if (sout_last4 !== 1'b1) begin
      fails++;
      $display("FAIL loopback last: got %b want 1", sout_last4);
    end
    step();
    tests++;
    if (sipo_q !== 4'b0110) begin
      fails++;
      $display("FAIL loopback sipo_q: got %b want 0110", sipo_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_bits;
    exp_bits = 4'b0001;
    din4 = 4'hF; din_valid4 = 1'b1;
    step();
    din_valid4 = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    tests++;
    if ({sout4, sout_valid4, sout_last4, din_ready4} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid: got {sout,valid,last,ready}=%b want 0001",
               {sout4, sout_valid4, sout_last4, din_ready4});
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (sout_valid4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid release: got valid=%b want 0", sout_valid4);
    end
    din4 = 4'h1; din_valid4 = 1'b1;
    step();
    din_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({sout4, sout_valid4, sout_last4} !== {exp_bits[i], 1'b1, (i == 3)}) begin
        fails++;
        $display("FAIL reset_mid resend bit %0d: got {sout,valid,last}=%b want %b", i,
                 {sout4, sout_valid4, sout_last4}, {exp_bits[i], 1'b1, (i == 3)});
      end
      step();
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_seq;
    exp_seq = 8'b1100_0101; // expected bits in transmit order, index 7 first
    din8 = 8'hC5; din_valid8 = 1'b1;
    step();
    din_valid8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({sout8, sout_valid8, sout_last8} !== {exp_seq[7-i], 1'b1, (i == 7)}) begin
        fails++;
        $display("FAIL msb_first bit %0d: got {sout,valid,last}=%b want %b", i,
                 {sout8, sout_valid8, sout_last8}, {exp_seq[7-i], 1'b1, (i == 7)});
      end
      step();
    end
    tests++;
    if ({sout8, sout_valid8, din_ready8} !== 3'b001) begin
      fails++;
      $display("FAIL msb_first idle: got {sout,valid,ready}=%b want 001", {sout8, sout_valid8, din_ready8});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_loopback();
    test_reset_mid();
    test_msb_first();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
